tlk2711_tx_sched: RTL



---
 rtl/tlk2711_tx_sched_if.sv | 31 +++
 rtl/tlk2711_tx_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_tx_sched_if
// Description : Command/completion bus between the TX scheduler and the
//               TX DMA-read datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlk2711_tx_sched_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [15:0]           cmd_len;
    logic                  cmd_last;
    logic [15:0]           cmd_idx;
    logic                  pkt_done;

    // Scheduler side: issues commands, receives ready and packet completion
    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_last, cmd_idx,
        input  cmd_ready, pkt_done
    );

    // Datapath side
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_last, cmd_idx,
        output cmd_ready, pkt_done
    );
endinterface
`default_nettype wire

// File: rtl/tlk2711_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_tx_sched
// Description : TX file-transfer sequencer. Latches the TX register set on a
//               start pulse, validates it, then issues one DMA-read command
//               per packet (body packets, then optional tail), waiting for
//               packet-done between commands. Raises a completion interrupt
//               and exposes a 10-bit status word.
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_tx_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_soft_rst,
    input  logic                  i_tx_config_done,
    input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
    input  logic [31:0]           i_tx_total_length,
    input  logic [15:0]           i_tx_packet_body,
    input  logic [15:0]           i_tx_packet_tail,
    input  logic [15:0]           i_tx_body_num,
    tlk2711_tx_sched_if.master    cmd_if,
    output logic                  o_tx_interrupt,
    output logic                  o_busy,
    output logic [9:0]            o_status
);

    localparam logic [31:0] C_GAP     = 32'(GAP_CYCLES);
    localparam logic [31:0] C_TIMEOUT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_total;
    logic [15:0]           r_body;
    logic [15:0]           r_tail;
    logic [15:0]           r_num;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_idx;
    logic [15:0]           r_len;
    logic                  r_last;
    logic                  r_cmd_valid;
    logic [31:0]           r_cnt;
    logic                  r_irq;
    logic                  r_cfg_err;
    logic                  r_timeout;
    logic                  r_done;
    logic                  r_overrun;

    logic [31:0]           w_product;
    logic [32:0]           w_sum;
    logic                  w_cfg_bad;
    logic [15:0]           w_next_idx;

    // Body packets come first; every index at or past body_num is the tail
    function automatic logic [15:0] f_len(input logic [15:0] idx, input logic [15:0] num,
                                          input logic [15:0] body, input logic [15:0] tail);
        return (idx < num) ? body : tail;
    endfunction

    // With no tail, the final body packet closes the file
    function automatic logic f_last(input logic [15:0] idx, input logic [15:0] num,
                                    input logic [15:0] tail);
        if (tail != 16'd0)
            return idx == num;
        else
            return ({1'b0, idx} + 17'd1) == {1'b0, num};
    endfunction

    // Configuration consistency: the split must add up exactly to the total
    assign w_product  = 32'(r_num) * 32'(r_body);
    assign w_sum      = {1'b0, w_product} + {17'd0, r_tail};
    assign w_cfg_bad  = (w_sum != {1'b0, r_total}) || (r_total == 32'd0) ||
                        ((r_num != 16'd0) && (r_body == 16'd0));
    assign w_next_idx = r_idx + 16'd1;

    assign cmd_if.cmd_valid = r_cmd_valid;
    assign cmd_if.cmd_addr  = r_addr;
    assign cmd_if.cmd_len   = r_len;
    assign cmd_if.cmd_last  = r_last;
    assign cmd_if.cmd_idx   = r_idx;

    assign o_tx_interrupt = r_irq;
    assign o_busy         = (r_state != S_IDLE);
    assign o_status       = {2'b00, r_state, r_overrun, r_done, r_timeout, r_cfg_err, o_busy};

    // Transfer sequencer: state, latched config, command payload and sticky status
    always_ff @(posedge clk) begin
        if (rst || i_soft_rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_total     <= '0;
            r_body      <= '0;
            r_tail      <= '0;
            r_num       <= '0;
            r_addr      <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_last      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cnt       <= '0;
            r_irq       <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (i_tx_config_done && (r_state != S_IDLE))
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_tx_config_done) begin
                        r_base    <= i_tx_base_addr;
                        r_total   <= i_tx_total_length;
                        r_body    <= i_tx_packet_body;
                        r_tail    <= i_tx_packet_tail;
                        r_num     <= i_tx_body_num;
                        r_cfg_err <= 1'b0;
                        r_timeout <= 1'b0;
                        r_done    <= 1'b0;
                        r_overrun <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                        r_irq     <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_addr      <= r_base;
                        r_idx       <= 16'd0;
                        r_len       <= f_len(16'd0, r_num, r_body, r_tail);
                        r_last      <= f_last(16'd0, r_num, r_tail);
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_if.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (cmd_if.pkt_done) begin
                        r_addr <= r_addr + ADDR_WIDTH'(r_len);
                        r_idx  <= w_next_idx;
                        r_len  <= f_len(w_next_idx, r_num, r_body, r_tail);
                        r_last <= f_last(w_next_idx, r_num, r_tail);
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (C_GAP == 32'd0) begin
                            r_cmd_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                        end
                    end else if ((C_TIMEOUT != 32'd0) && (r_cnt == C_TIMEOUT)) begin
                        r_timeout <= 1'b1;
                        r_irq     <= 1'b1;
                        r_state   <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == C_GAP - 32'd1) begin
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                S_ERROR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
